// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
// Bundle of the fetch-side lookup signals and the execute-side training
// signals exchanged between the pipeline and the branch predictor.
//   master : pipeline side (drives fetch_pc and update_*, receives pred_*)
//   slave  : predictor side (receives fetch_pc and update_*, drives pred_*)
// Signals:
//   fetch_pc         PC being fetched this cycle
//   pred_taken       predicted taken (counter MSB AND BTB hit)
//   pred_pht_idx     PHT index used for this lookup, carried down the pipe
//   pred_btb_hit     BTB entry valid with matching tag
//   pred_btb_target  stored BTB target, 0 on miss
//   pred_next_pc     predicted next fetch PC
//   update_en        a branch/jump was resolved this cycle
//   update_is_branch resolved instruction is conditional
//   update_taken     actual outcome
//   update_pc        PC of the resolved instruction
//   update_target    actual target
//   update_pht_idx   PHT index produced at fetch for that instruction
// ---------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int PHT_IDX_W = 8
);
    logic [31:0]          fetch_pc;
    logic                 pred_taken;
    logic [PHT_IDX_W-1:0] pred_pht_idx;
    logic                 pred_btb_hit;
    logic [31:0]          pred_btb_target;
    logic [31:0]          pred_next_pc;
    logic                 update_en;
    logic                 update_is_branch;
    logic                 update_taken;
    logic [31:0]          update_pc;
    logic [31:0]          update_target;
    logic [PHT_IDX_W-1:0] update_pht_idx;

    modport master (
        output fetch_pc,
        input  pred_taken,
        input  pred_pht_idx,
        input  pred_btb_hit,
        input  pred_btb_target,
        input  pred_next_pc,
        output update_en,
        output update_is_branch,
        output update_taken,
        output update_pc,
        output update_target,
        output update_pht_idx
    );

    modport slave (
        input  fetch_pc,
        output pred_taken,
        output pred_pht_idx,
        output pred_btb_hit,
        output pred_btb_target,
        output pred_next_pc,
        input  update_en,
        input  update_is_branch,
        input  update_taken,
        input  update_pc,
        input  update_target,
        input  update_pht_idx
    );
endinterface

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Fetch-side gshare direction predictor plus direct-mapped BTB.
// Lookup is purely combinational from fetch_pc and the current state, so the
// prediction bundle is available in the same cycle the PC is fetched.
// Training comes from the execute stage and takes effect on the next rising
// edge; a lookup in the same cycle as an update sees the old contents.
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  asynchronous active-high reset
//   bus  branch_predictor_if.slave (lookup and training signals)
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int PHT_IDX_W = 8,
    parameter int BTB_IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_predictor_if.slave      bus
);
    localparam int PHT_SIZE = 1 << PHT_IDX_W;
    localparam int BTB_SIZE = 1 << BTB_IDX_W;
    localparam int TAG_W    = 32 - BTB_IDX_W - 2;

    // State
    logic [1:0]           pht_r        [PHT_SIZE];
    logic [PHT_IDX_W-1:0] ghr_r;
    logic                 btb_valid_r  [BTB_SIZE];
    logic [TAG_W-1:0]     btb_tag_r    [BTB_SIZE];
    logic [31:0]          btb_target_r [BTB_SIZE];

    // Lookup path
    logic [PHT_IDX_W-1:0] fetch_pht_idx_s;
    logic [BTB_IDX_W-1:0] fetch_btb_idx_s;
    logic [TAG_W-1:0]     fetch_tag_s;
    logic                 btb_hit_s;
    logic [31:0]          btb_target_s;
    logic                 taken_s;
    logic [31:0]          next_pc_s;

    // Update path decode
    logic [BTB_IDX_W-1:0] upd_btb_idx_s;
    logic [TAG_W-1:0]     upd_tag_s;

    // Two-bit saturating counter step; never wraps past 0 or 3.
    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        case ({taken, ctr})
            3'b1_11: res = 2'b11;
            3'b0_00: res = 2'b00;
            3'b1_00,
            3'b1_01,
            3'b1_10: res = ctr + 2'd1;
            3'b0_01,
            3'b0_10,
            3'b0_11: res = ctr - 2'd1;
            default: res = ctr;
        endcase
        return res;
    endfunction

    // Combinational lookup of PHT and BTB for the current fetch PC.
    always_comb begin
        fetch_pht_idx_s = bus.fetch_pc[PHT_IDX_W+1:2] ^ ghr_r;
        fetch_btb_idx_s = bus.fetch_pc[BTB_IDX_W+1:2];
        fetch_tag_s     = bus.fetch_pc[31:BTB_IDX_W+2];
        btb_hit_s       = btb_valid_r[fetch_btb_idx_s] &&
                          (btb_tag_r[fetch_btb_idx_s] == fetch_tag_s);
        if (btb_hit_s) begin
            btb_target_s = btb_target_r[fetch_btb_idx_s];
        end else begin
            btb_target_s = 32'h0000_0000;
        end
        // A strongly/weakly taken counter alone is not enough: without a
        // BTB hit there is no target to redirect to.
        taken_s = pht_r[fetch_pht_idx_s][1] & btb_hit_s;
        if (taken_s) begin
            next_pc_s = btb_target_s;
        end else begin
            next_pc_s = bus.fetch_pc + 32'd4;
        end
    end

    assign bus.pred_taken      = taken_s;
    assign bus.pred_pht_idx    = fetch_pht_idx_s;
    assign bus.pred_btb_hit    = btb_hit_s;
    assign bus.pred_btb_target = btb_target_s;
    assign bus.pred_next_pc    = next_pc_s;

    assign upd_btb_idx_s = bus.update_pc[BTB_IDX_W+1:2];
    assign upd_tag_s     = bus.update_pc[31:BTB_IDX_W+2];

    // PHT training: only resolved conditional branches move a counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht_r[i] <= 2'b01;
            end
        end else if (bus.update_en && bus.update_is_branch) begin
            pht_r[bus.update_pht_idx] <= sat_step(pht_r[bus.update_pht_idx], bus.update_taken);
        end
    end

    // Non-speculative global history: shifted only by resolved branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_r <= '0;
        end else if (bus.update_en && bus.update_is_branch) begin
            ghr_r <= {ghr_r[PHT_IDX_W-2:0], bus.update_taken};
        end
    end

    // BTB fill on any taken branch or jump; overwrites an aliasing entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_SIZE; i++) begin
                btb_valid_r[i]  <= 1'b0;
                btb_tag_r[i]    <= '0;
                btb_target_r[i] <= 32'h0000_0000;
            end
        end else if (bus.update_en && bus.update_taken) begin
            btb_valid_r[upd_btb_idx_s]  <= 1'b1;
            btb_tag_r[upd_btb_idx_s]    <= upd_tag_s;
            btb_target_r[upd_btb_idx_s] <= bus.update_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed bench for branch_predictor with hand-computed expected values.
// Inputs are driven on the falling edge and outputs sampled 1 ns later, well
// away from the rising edge where state changes.
// ---------------------------------------------------------------------------
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    branch_predictor_if #(.PHT_IDX_W(8)) bus ();

    branch_predictor #(.PHT_IDX_W(8), .BTB_IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One-cycle training pulse, applied at the next rising edge.
    task automatic upd(input logic br, input logic tk, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic [7:0] idx);
        @(negedge clk);
        bus.update_is_branch = br;
        bus.update_taken     = tk;
        bus.update_pc        = pc;
        bus.update_target    = tgt;
        bus.update_pht_idx   = idx;
        bus.update_en        = 1'b1;
        @(negedge clk);
        bus.update_en        = 1'b0;
    endtask

    // Set fetch PC and let the combinational lookup settle.
    task automatic fetch(input logic [31:0] pc);
        bus.fetch_pc = pc;
        #1;
    endtask

    initial begin
        bus.fetch_pc         = 32'h0000_0100;
        bus.update_en        = 1'b0;
        bus.update_is_branch = 1'b0;
        bus.update_taken     = 1'b0;
        bus.update_pc        = 32'h0;
        bus.update_target    = 32'h0;
        bus.update_pht_idx   = 8'h00;
        #1 rst = 1'b1;
        #1;

        // Reset values
        chk("rst_pht_idx", 32'(bus.pred_pht_idx), 32'h40);
        chk("rst_taken",   32'(bus.pred_taken),   32'h0);
        chk("rst_hit",     32'(bus.pred_btb_hit), 32'h0);
        chk("rst_target",  bus.pred_btb_target,   32'h0);
        chk("rst_next",    bus.pred_next_pc,      32'h104);
        fetch(32'hFFFF_FFFC);
        chk("wrap_next",   bus.pred_next_pc,      32'h0);
        chk("wrap_idx",    32'(bus.pred_pht_idx), 32'hFF);

        @(negedge clk);
        rst = 1'b0;

        // Saturation: counter 0x40 -> 3 -> 2, GHR -> 0x3E
        upd(1'b0, 1'b1, 32'h1F8, 32'h400, 8'h00);
        for (int i = 0; i < 5; i++) upd(1'b1, 1'b1, 32'h300, 32'h380, 8'h40);
        upd(1'b1, 1'b0, 32'h300, 32'h380, 8'h40);
        fetch(32'h0);
        chk("ghr_3e",      32'(bus.pred_pht_idx), 32'h3E);
        fetch(32'h1F8);
        chk("sat_idx",     32'(bus.pred_pht_idx), 32'h40);
        chk("sat_hit",     32'(bus.pred_btb_hit), 32'h1);
        chk("sat_taken",   32'(bus.pred_taken),   32'h1);
        chk("sat_next",    bus.pred_next_pc,      32'h400);

        // BTB aliasing at index 0
        upd(1'b0, 1'b1, 32'h100, 32'h200, 8'h00);
        upd(1'b0, 1'b1, 32'h140, 32'h300, 8'h00);
        fetch(32'h100);
        chk("alias_hit100", 32'(bus.pred_btb_hit), 32'h0);
        chk("alias_tgt100", bus.pred_btb_target,   32'h0);
        fetch(32'h140);
        chk("alias_hit140", 32'(bus.pred_btb_hit), 32'h1);
        chk("alias_tgt140", bus.pred_btb_target,   32'h300);
        chk("alias_idx140", 32'(bus.pred_pht_idx), 32'h6E);
        chk("alias_tk140",  32'(bus.pred_taken),   32'h0);
        chk("alias_nx140",  bus.pred_next_pc,      32'h144);

        // Same-cycle hazard: lookup 0x140 (idx 0x6E, counter 01) while
        // training idx 0x6E taken
        @(negedge clk);
        bus.fetch_pc         = 32'h140;
        bus.update_is_branch = 1'b1;
        bus.update_taken     = 1'b1;
        bus.update_pc        = 32'h208;
        bus.update_target    = 32'h500;
        bus.update_pht_idx   = 8'h6E;
        bus.update_en        = 1'b1;
        #1;
        chk("haz_taken",   32'(bus.pred_taken),   32'h0);
        chk("haz_hit",     32'(bus.pred_btb_hit), 32'h1);
        chk("haz_idx",     32'(bus.pred_pht_idx), 32'h6E);
        @(negedge clk);
        bus.update_en = 1'b0;
        #1;
        // GHR now 0x7D: 0x50 ^ 0x7D = 0x2D
        chk("haz_newidx",  32'(bus.pred_pht_idx), 32'h2D);
        chk("haz_newtk",   32'(bus.pred_taken),   32'h0);
        fetch(32'h208);
        chk("haz_hit208",  32'(bus.pred_btb_hit), 32'h1);
        chk("haz_tgt208",  bus.pred_btb_target,   32'h500);
        chk("haz_idx208",  32'(bus.pred_pht_idx), 32'hFF);

        // update_en=0 with the other update inputs toggling
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.update_is_branch = 1'($urandom_range(1, 0));
            bus.update_taken     = 1'($urandom_range(1, 0));
            bus.update_pc        = $urandom;
            bus.update_target    = $urandom;
            bus.update_pht_idx   = 8'($urandom_range(255, 0));
        end
        @(negedge clk);
        fetch(32'h140);
        chk("idle_idx140", 32'(bus.pred_pht_idx), 32'h2D);
        chk("idle_hit140", 32'(bus.pred_btb_hit), 32'h1);
        chk("idle_tgt140", bus.pred_btb_target,   32'h300);
        fetch(32'h1F8);
        chk("idle_idx1f8", 32'(bus.pred_pht_idx), 32'h03);
        chk("idle_hit1f8", 32'(bus.pred_btb_hit), 32'h1);
        chk("idle_nx1f8",  bus.pred_next_pc,      32'h1FC);

        // Asynchronous reset between edges
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_hit",    32'(bus.pred_btb_hit), 32'h0);
        chk("arst_tgt",    bus.pred_btb_target,   32'h0);
        chk("arst_taken",  32'(bus.pred_taken),   32'h0);
        chk("arst_next",   bus.pred_next_pc,      32'h1FC);
        chk("arst_idx",    32'(bus.pred_pht_idx), 32'h7E);
        #1 rst = 1'b0;
        @(negedge clk);
        fetch(32'h140);
        chk("post_hit140", 32'(bus.pred_btb_hit), 32'h0);
        chk("post_idx140", 32'(bus.pred_pht_idx), 32'h50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
